// File: rtl/rr_arb_mux.sv
// CH-input valid/ready selector with fixed-priority or round-robin arbitration
// feeding a single registered output slice (1-cycle latency, full throughput).
module rr_arb_mux #(
    parameter int N    = 32,
    parameter int CH   = 4,
    parameter int MODE = 1,
    localparam int SW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sel
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gidx;
    logic          any_grant;
    logic          load;

    assign load = ~out_valid | out_ready;

    // Search order starts at ptr in round-robin mode, at 0 in fixed-priority mode.
    always_comb begin
        int            idx;
        logic [SW-1:0] idx_sw;
        gidx      = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_sw    = '0;
        for (int k = 0; k < CH; k++) begin
            if (MODE == 0) begin
                idx = k;
            end else begin
                idx = int'(ptr) + k;
                if (idx >= CH) idx = idx - CH;
            end
            idx_sw = idx[SW-1:0];
            if (!any_grant && in_valid[idx_sw]) begin
                any_grant = 1'b1;
                gidx      = idx_sw;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && any_grant && !rst) in_ready[gidx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gidx)*N +: N];
                out_sel   <= gidx;
                if (MODE == 1) begin
                    ptr <= (gidx == SW'(CH - 1)) ? '0 : gidx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
